// File: rtl/mem_stage_pkg.sv
// Shared core types: EX->MEM->WB pipeline bus, memory-stage FSM states
// and RV32 load/store funct3 encodings.
package core;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic            is_load;
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            rd_we;
    logic            misaligned;
  } pipeline_bus_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational load/store lane alignment: byte enables, replicated store
// data, load extraction with sign/zero extension, and alignment checking.
module lsu_align
  import core::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata[{off, 3'b000} +: 8];
  assign half_s = off[1] ? rdata[31:16] : rdata[15:0];

  // Store lane encoding
  always_comb begin
    be    = 4'b0000;
    wdata = rs2_data;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{rs2_data[7:0]}};
      end
      F3_SH: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wdata = {2{rs2_data[15:0]}};
      end
      F3_SW: begin
        be    = 4'b1111;
        wdata = rs2_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = rs2_data;
      end
    endcase
  end

  // Load extraction
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  load_data = {24'h000000, byte_s};
      F3_LH:   load_data = {{16{half_s[15]}}, half_s};
      F3_LHU:  load_data = {16'h0000, half_s};
      F3_LW:   load_data = rdata;
      default: load_data = rdata;
    endcase
  end

  // Alignment check (same funct3 codes for loads and stores)
  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: misaligned = off[0];
      F3_LW:         misaligned = (off != 2'b00);
      default:       misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/gnt/rvalid
// port, stalls upstream while an access is in flight, registers WB bus.
module mem_stage
  import core::*;
(
  input  logic            clk,
  input  logic            rst,
  input  pipeline_bus_t   bus_i,
  output logic            stall_o,
  output pipeline_bus_t   mem_bus_o,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  mem_state_e      state_r, state_s;
  pipeline_bus_t   hold_r, hold_s, out_s;
  logic            req_s, stall_s, misal_s;
  logic [2:0]      sel_f3_s;
  logic [XLEN-1:0] sel_result_s, sel_rs2_s, wdata_s, load_data_s;
  logic            sel_store_s;
  logic [3:0]      be_s;

  // Request fields come from the live bus in IDLE, from the holding register otherwise
  assign sel_f3_s     = (state_r == IDLE) ? bus_i.funct3   : hold_r.funct3;
  assign sel_result_s = (state_r == IDLE) ? bus_i.result   : hold_r.result;
  assign sel_rs2_s    = (state_r == IDLE) ? bus_i.rs2_data : hold_r.rs2_data;
  assign sel_store_s  = (state_r == IDLE) ? bus_i.is_store : hold_r.is_store;

  lsu_align u_lsu_align (
    .funct3     (sel_f3_s),
    .off        (sel_result_s[1:0]),
    .rs2_data   (sel_rs2_s),
    .rdata      (dmem_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s),
    .misaligned (misal_s)
  );

  // Next-state, holding-register capture and next WB bus
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    out_s   = '0;
    req_s   = 1'b0;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!(bus_i.valid && (bus_i.is_load || bus_i.is_store))) begin
          out_s = bus_i;
        end else if (misal_s) begin
          out_s            = bus_i;
          out_s.misaligned = 1'b1;
          out_s.rd_we      = 1'b0;
        end else begin
          req_s  = 1'b1;
          hold_s = bus_i;
          if (bus_i.is_store && dmem_gnt) begin
            out_s = bus_i;
          end else begin
            stall_s = 1'b1;
            state_s = (bus_i.is_load && dmem_gnt) ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req_s = 1'b1;
        if (dmem_gnt && hold_r.is_store) begin
          out_s   = hold_r;
          state_s = IDLE;
        end else if (dmem_gnt) begin
          stall_s = 1'b1;
          state_s = WAIT_RVALID;
        end else begin
          stall_s = 1'b1;
        end
      end
      WAIT_RVALID: begin
        // A response arriving together with the grant never reaches here
        if (dmem_rvalid) begin
          out_s        = hold_r;
          out_s.result = load_data_s;
          state_s      = IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Combinational port outputs are forced low while reset is asserted
  assign stall_o    = stall_s & rst;
  assign dmem_req   = req_s & rst;
  assign dmem_we    = dmem_req & sel_store_s;
  assign dmem_addr  = dmem_req ? {sel_result_s[XLEN-1:2], 2'b00} : 32'h0000_0000;
  assign dmem_be    = dmem_we ? be_s : 4'b0000;
  assign dmem_wdata = dmem_we ? wdata_s : 32'h0000_0000;

  // State, holding register and registered WB bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      hold_r    <= '0;
      mem_bus_o <= '0;
    end else begin
      state_r   <= state_s;
      hold_r    <= hold_s;
      mem_bus_o <= out_s;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected WB results go into a scoreboard
// queue at issue time and are compared when mem_bus_o.valid appears.
module tb_mem_stage;
  import core::*;

  logic            clk;
  logic            rst;
  pipeline_bus_t   bus_i;
  logic            stall_o;
  pipeline_bus_t   mem_bus_o;
  logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;

  int pass_cnt = 0;
  int total    = 0;
  pipeline_bus_t exp_q[$];
  pipeline_bus_t e;

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .bus_i       (bus_i),
    .stall_o     (stall_o),
    .mem_bus_o   (mem_bus_o),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic pipeline_bus_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] res, input logic [31:0] rs2,
                                       input logic [4:0] rd, input logic we);
    pipeline_bus_t b;
    b            = '0;
    b.valid      = 1'b1;
    b.is_load    = ld;
    b.is_store   = st;
    b.funct3     = f3;
    b.result     = res;
    b.rs2_data   = rs2;
    b.rd         = rd;
    b.rd_we      = we;
    return b;
  endfunction

  // Advance one cycle, sample registered output, and score any valid result
  task automatic tick();
    pipeline_bus_t x;
    @(negedge clk);
    #1;
    if (mem_bus_o.valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_valid", {31'b0, mem_bus_o.valid}, 32'd0);
      end else begin
        x = exp_q.pop_front();
        chk("sb_result", mem_bus_o.result, x.result);
        chk("sb_rd", {27'b0, mem_bus_o.rd}, {27'b0, x.rd});
        chk("sb_rd_we", {31'b0, mem_bus_o.rd_we}, {31'b0, x.rd_we});
        chk("sb_misaligned", {31'b0, mem_bus_o.misaligned}, {31'b0, x.misaligned});
      end
    end
  endtask

  initial begin
    rst = 1'b0; bus_i = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick();
    chk("rst_valid", {31'b0, mem_bus_o.valid}, 32'd0);
    chk("rst_result", mem_bus_o.result, 32'h0);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    rst = 1'b1;
    tick();

    // ADD pass-through
    bus_i = mk(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    exp_q.push_back(bus_i);
    #1;
    chk("add_stall", {31'b0, stall_o}, 32'd0);
    chk("add_req", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("add_drain", exp_q.size(), 32'd0);
    bus_i = '0;

    // LB 0x1003, immediate grant, response next cycle
    bus_i = mk(1'b1, 1'b0, F3_LB, 32'h0000_1003, 32'h0, 5'd7, 1'b1);
    e = bus_i; e.result = 32'hFFFF_FF80; exp_q.push_back(e);
    dmem_gnt = 1'b1;
    #1;
    chk("lb_req", {31'b0, dmem_req}, 32'd1);
    chk("lb_we", {31'b0, dmem_we}, 32'd0);
    chk("lb_addr", dmem_addr, 32'h0000_1000);
    chk("lb_be", {28'b0, dmem_be}, 32'd0);
    chk("lb_stall_issue", {31'b0, stall_o}, 32'd1);
    tick();
    chk("lb_bubble", {31'b0, mem_bus_o.valid}, 32'd0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    #1;
    chk("lb_stall_rvalid", {31'b0, stall_o}, 32'd0);
    chk("lb_req_wait", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("lb_drain", exp_q.size(), 32'd0);
    bus_i = '0; dmem_rvalid = 1'b0;

    // SH 0x2002 with grant withheld three cycles
    bus_i = mk(1'b0, 1'b1, F3_SH, 32'h0000_2002, 32'hABCD_1234, 5'd0, 1'b0);
    exp_q.push_back(bus_i);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_req", {31'b0, dmem_req}, 32'd1);
      chk("sh_we", {31'b0, dmem_we}, 32'd1);
      chk("sh_addr", dmem_addr, 32'h0000_2000);
      chk("sh_be", {28'b0, dmem_be}, 32'h0000_000C);
      chk("sh_wdata", dmem_wdata, 32'h1234_1234);
      chk("sh_stall", {31'b0, stall_o}, 32'd1);
      tick();
      chk("sh_bubble", {31'b0, mem_bus_o.valid}, 32'd0);
    end
    dmem_gnt = 1'b1;
    #1;
    chk("sh_gnt_be", {28'b0, dmem_be}, 32'h0000_000C);
    chk("sh_gnt_stall", {31'b0, stall_o}, 32'd0);
    tick();
    chk("sh_drain", exp_q.size(), 32'd0);
    bus_i = '0; dmem_gnt = 1'b0;

    // SB 0x41 immediate grant
    bus_i = mk(1'b0, 1'b1, F3_SB, 32'h0000_0041, 32'h1234_565A, 5'd0, 1'b0);
    exp_q.push_back(bus_i);
    dmem_gnt = 1'b1;
    #1;
    chk("sb_be", {28'b0, dmem_be}, 32'h0000_0002);
    chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    chk("sb_stall", {31'b0, stall_o}, 32'd0);
    tick();
    chk("sb_drain", exp_q.size(), 32'd0);
    bus_i = '0; dmem_gnt = 1'b0;

    // LW 0x3001 misaligned: no request
    bus_i = mk(1'b1, 1'b0, F3_LW, 32'h0000_3001, 32'h0, 5'd9, 1'b1);
    e = bus_i; e.misaligned = 1'b1; e.rd_we = 1'b0; exp_q.push_back(e);
    #1;
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall_o}, 32'd0);
    tick();
    chk("mis_drain", exp_q.size(), 32'd0);
    bus_i = '0;

    // LH 0x52: grant late, response in the grant cycle must be ignored
    bus_i = mk(1'b1, 1'b0, F3_LH, 32'h0000_0052, 32'h0, 5'd4, 1'b1);
    e = bus_i; e.result = 32'hFFFF_8001; exp_q.push_back(e);
    #1;
    chk("lh_stall0", {31'b0, stall_o}, 32'd1);
    tick();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    chk("lh_stall_gnt", {31'b0, stall_o}, 32'd1);
    tick();
    chk("lh_bubble", {31'b0, mem_bus_o.valid}, 32'd0);
    dmem_gnt = 1'b0; dmem_rdata = 32'h8001_0000;
    #1;
    chk("lh_stall_rv", {31'b0, stall_o}, 32'd0);
    tick();
    chk("lh_drain", exp_q.size(), 32'd0);
    bus_i = '0; dmem_rvalid = 1'b0;

    // LHU 0x0 then reset before the response
    bus_i = mk(1'b1, 1'b0, F3_LHU, 32'h0000_0000, 32'h0, 5'd3, 1'b1);
    dmem_gnt = 1'b1;
    #1;
    chk("lhu_req", {31'b0, dmem_req}, 32'd1);
    tick();
    dmem_gnt = 1'b0; rst = 1'b0;
    #1;
    chk("rstmid_req", {31'b0, dmem_req}, 32'd0);
    chk("rstmid_stall", {31'b0, stall_o}, 32'd0);
    chk("rstmid_valid", {31'b0, mem_bus_o.valid}, 32'd0);
    bus_i = '0;
    tick();
    rst = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("late_rvalid", {31'b0, mem_bus_o.valid}, 32'd0);
    dmem_rvalid = 1'b0;

    // Back-to-back LW 0x10 / 0x14, two-cycle response latency
    bus_i = mk(1'b1, 1'b0, F3_LW, 32'h0000_0010, 32'h0, 5'd1, 1'b1);
    e = bus_i; e.result = 32'hAAAA_0001; exp_q.push_back(e);
    dmem_gnt = 1'b1;
    #1;
    chk("b2b_req1", {31'b0, dmem_req}, 32'd1);
    chk("b2b_addr1", dmem_addr, 32'h0000_0010);
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("b2b_wait_req", {31'b0, dmem_req}, 32'd0);
    chk("b2b_wait_stall", {31'b0, stall_o}, 32'd1);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_0001;
    #1;
    chk("b2b_rv1_stall", {31'b0, stall_o}, 32'd0);
    tick();
    chk("b2b_out1", exp_q.size(), 32'd0);
    dmem_rvalid = 1'b0;
    bus_i = mk(1'b1, 1'b0, F3_LW, 32'h0000_0014, 32'h0, 5'd2, 1'b1);
    e = bus_i; e.result = 32'hBBBB_0002; exp_q.push_back(e);
    dmem_gnt = 1'b1;
    #1;
    chk("b2b_req2", {31'b0, dmem_req}, 32'd1);
    chk("b2b_addr2", dmem_addr, 32'h0000_0014);
    tick();
    dmem_gnt = 1'b0;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBBBB_0002;
    tick();
    chk("b2b_drain", exp_q.size(), 32'd0);
    dmem_rvalid = 1'b0; bus_i = '0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
